// File: rtl/timing_seq.sv
// timing_seq: 8-state instruction-cycle phase/strobe generator; `define TIMING_SEQ_STOP_EN enables stp/stp_ack stop control
module timing_seq #(
   parameter int SLOT_TICKS = 1,
   parameter int POC_CYCLES = 2
) (
   input  logic       sysclk,
   input  logic       poc_n,
   input  logic       stp,
   output logic       clk1,
   output logic       clk2,
   output logic       sync_n,
   output logic       a12,
   output logic       m12,
   output logic       x12,
   output logic       a22,
   output logic       a32,
   output logic       m22,
   output logic       x22,
   output logic       x32,
   output logic       x21_clk2,
   output logic       x31_clk2,
   output logic       poc,
   output logic       stp_ack,
   output logic [2:0] state
);
`ifdef TIMING_SEQ_STOP_EN
   localparam bit STOP_EN = 1'b1;
`else
   localparam bit STOP_EN = 1'b0;
`endif
   typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} st_t;
   st_t        st, st_nx;
   logic [3:0] tick, tick_nx;
   logic [1:0] slot, slot_nx;
   logic [2:0] poc_cnt, poc_cnt_nx;
   logic       run, stopped, stopped_nx, poc_nx, last_tick, end_s3, s2;
   assign state = st;
   // next position: run is clear for the first edge after release so that edge lands on A1 S0
   always_comb begin
      last_tick  = tick == 4'(SLOT_TICKS - 1);
      end_s3     = run && last_tick && slot == 2'd3;
      tick_nx    = (!run || last_tick) ? 4'd0 : tick + 4'd1;
      slot_nx    = (run && last_tick) ? slot + 2'd1 : slot;
      st_nx      = (end_s3 && !stopped) ? st_t'(st + 3'd1) : st;
      stopped_nx = (end_s3 && (stopped || st == X3)) ? (STOP_EN && !poc && stp) : stopped;
      poc_cnt_nx = (end_s3 && !stopped && st == X3 && poc) ? poc_cnt + 3'd1 : poc_cnt;
      poc_nx     = poc && poc_cnt_nx != 3'(POC_CYCLES);
      s2         = slot_nx == 2'd2 && !stopped_nx;
   end
   // position, stop and power-on-clear state
   always_ff @(posedge sysclk or negedge poc_n) begin
      if (!poc_n) begin
         run     <= 1'b0;
         st      <= A1;
         tick    <= 4'd0;
         slot    <= 2'd0;
         stopped <= 1'b0;
         poc_cnt <= 3'd0;
         poc     <= 1'b1;
      end else begin
         run     <= 1'b1;
         st      <= st_nx;
         tick    <= tick_nx;
         slot    <= slot_nx;
         stopped <= stopped_nx;
         poc_cnt <= poc_cnt_nx;
         poc     <= poc_nx;
      end
   end
   // glitch-free registered phase clocks and strobes decoded from the next position
   always_ff @(posedge sysclk or negedge poc_n) begin
      if (!poc_n) begin
         clk1     <= 1'b0;
         clk2     <= 1'b0;
         sync_n   <= 1'b1;
         a12      <= 1'b0;
         a22      <= 1'b0;
         a32      <= 1'b0;
         m12      <= 1'b0;
         m22      <= 1'b0;
         x12      <= 1'b0;
         x22      <= 1'b0;
         x32      <= 1'b0;
         x21_clk2 <= 1'b1;
         x31_clk2 <= 1'b1;
         stp_ack  <= 1'b0;
      end else begin
         clk1     <= slot_nx == 2'd0;
         clk2     <= slot_nx == 2'd2;
         sync_n   <= !(st_nx == A1 && !stopped_nx);
         a12      <= s2 && st_nx == A1;
         a22      <= s2 && st_nx == A2;
         a32      <= s2 && st_nx == A3;
         m12      <= s2 && st_nx == M1;
         m22      <= s2 && st_nx == M2;
         x12      <= s2 && st_nx == X1;
         x22      <= s2 && st_nx == X2;
         x32      <= s2 && st_nx == X3;
         x21_clk2 <= !(s2 && st_nx == X2);
         x31_clk2 <= !(s2 && st_nx == X3);
         stp_ack  <= stopped_nx;
      end
   end
endmodule

// File: tb/tb_timing_seq.sv
// tb_timing_seq: random/directed checks of two timing_seq instances against a cycle-counter model
module tb_timing_seq;
`ifdef TIMING_SEQ_STOP_EN
   localparam bit STOP_EN = 1'b1;
`else
   localparam bit STOP_EN = 1'b0;
`endif
   localparam int S[2] = '{1, 3};
   localparam int P[2] = '{2, 1};
   logic sysclk = 1'b0;
   logic poc_n, stp;
   logic clk1[2], clk2[2], sync_n[2], a12[2], m12[2], x12[2], a22[2], a32[2], m22[2], x22[2], x32[2];
   logic x21_clk2[2], x31_clk2[2], poc[2], stp_ack[2];
   logic [2:0] state[2];
   int total = 0;
   int bad = 0;
   bit run[2] = '{0, 0};
   bit stopped[2] = '{0, 0};
   int n[2] = '{0, 0};
   int cyc[2] = '{0, 0};

   always #5 sysclk = ~sysclk;

   timing_seq #(.SLOT_TICKS(1), .POC_CYCLES(2)) u0 (
      .sysclk(sysclk), .poc_n(poc_n), .stp(stp), .clk1(clk1[0]), .clk2(clk2[0]), .sync_n(sync_n[0]),
      .a12(a12[0]), .m12(m12[0]), .x12(x12[0]), .a22(a22[0]), .a32(a32[0]), .m22(m22[0]), .x22(x22[0]),
      .x32(x32[0]), .x21_clk2(x21_clk2[0]), .x31_clk2(x31_clk2[0]), .poc(poc[0]), .stp_ack(stp_ack[0]),
      .state(state[0]));
   timing_seq #(.SLOT_TICKS(3), .POC_CYCLES(1)) u1 (
      .sysclk(sysclk), .poc_n(poc_n), .stp(stp), .clk1(clk1[1]), .clk2(clk2[1]), .sync_n(sync_n[1]),
      .a12(a12[1]), .m12(m12[1]), .x12(x12[1]), .a22(a22[1]), .a32(a32[1]), .m22(m22[1]), .x22(x22[1]),
      .x32(x32[1]), .x21_clk2(x21_clk2[1]), .x31_clk2(x31_clk2[1]), .poc(poc[1]), .stp_ack(stp_ack[1]),
      .state(state[1]));

   // model: n counts sysclk ticks inside the current instruction cycle (or stopped A1 pass)
   always @(posedge sysclk or negedge poc_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!poc_n) begin
            run[i] <= 1'b0;
            n[i] <= 0;
            stopped[i] <= 1'b0;
            cyc[i] <= 0;
         end else if (!run[i]) begin
            run[i] <= 1'b1;
            n[i] <= 0;
         end else if (n[i] == (stopped[i] ? 4 * S[i] : 32 * S[i]) - 1) begin
            n[i] <= 0;
            if (!stopped[i] && cyc[i] < P[i]) cyc[i] <= cyc[i] + 1;
            else stopped[i] <= STOP_EN && stp;
         end else n[i] <= n[i] + 1;
      end
   end

   function automatic logic [17:0] expv(input int i);
      int slot, st;
      logic [7:0] sb;
      if (!run[i]) return {3'b001, 8'h00, 2'b11, 2'b10, 3'd0};
      slot = (n[i] / S[i]) % 4;
      st = stopped[i] ? 0 : n[i] / (4 * S[i]);
      sb = (slot == 2 && !stopped[i]) ? 8'(1 << st) : 8'h00;
      return {slot == 0, slot == 2, !(st == 0 && !stopped[i]), sb[0], sb[3], sb[5], sb[1], sb[2], sb[4],
              sb[6], sb[7], !sb[6], !sb[7], cyc[i] < P[i], stopped[i], 3'(st)};
   endfunction

   function automatic logic [17:0] dutv(input int i);
      return {clk1[i], clk2[i], sync_n[i], a12[i], m12[i], x12[i], a22[i], a32[i], m22[i], x22[i], x32[i],
              x21_clk2[i], x31_clk2[i], poc[i], stp_ack[i], state[i]};
   endfunction

   task automatic test_reset;
      for (int k = 0; k < 4; k++) begin
         stp = 1'($urandom);
         @(negedge sysclk);
         for (int i = 0; i < 2; i++) begin
            total++;
            if (dutv(i) !== {3'b001, 8'h00, 2'b11, 2'b10, 3'd0}) begin
               bad++;
               $display("FAIL reset u%0d got=%h want=%h", i, dutv(i), {3'b001, 8'h00, 2'b11, 2'b10, 3'd0});
            end
         end
      end
   endtask

   task automatic test_free_run;
      poc_n = 1'b1;
      for (int k = 0; k < 192; k++) begin
         stp = (k < 60) ? 1'($urandom) : 1'b0;
         @(negedge sysclk);
         for (int i = 0; i < 2; i++) begin
            total++;
            if (dutv(i) !== expv(i)) begin
               bad++;
               $display("FAIL free_run u%0d k=%0d got=%h want=%h", i, k, dutv(i), expv(i));
            end
         end
         total += 4;
         if (clk1[0] !== (k % 4 == 0)) begin
            bad++;
            $display("FAIL clk1_phase k=%0d got=%b", k, clk1[0]);
         end
         if (sync_n[0] !== !(k % 32 < 4)) begin
            bad++;
            $display("FAIL sync_n_phase k=%0d got=%b", k, sync_n[0]);
         end
         if (poc[0] !== (k < 64)) begin
            bad++;
            $display("FAIL poc_release k=%0d got=%b want=%b", k, poc[0], k < 64);
         end
         if (m12[1] !== (k % 96 >= 42 && k % 96 <= 44)) begin
            bad++;
            $display("FAIL m12_slot3 k=%0d got=%b", k, m12[1]);
         end
      end
   endtask

   task automatic test_stop;
      for (int k = 0; k < 1600; k++) begin
         if ($urandom_range(15) == 0) stp = 1'($urandom);
         if (k >= 1000) stp = (k < 1300);
         @(negedge sysclk);
         for (int i = 0; i < 2; i++) begin
            total++;
            if (dutv(i) !== expv(i)) begin
               bad++;
               $display("FAIL stop u%0d k=%0d got=%h want=%h", i, k, dutv(i), expv(i));
            end
         end
         if (k == 1299) begin
            total++;
            if (stp_ack[0] !== STOP_EN) begin
               bad++;
               $display("FAIL stp_ack_held got=%b want=%b", stp_ack[0], STOP_EN);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      for (int r = 0; r < 6; r++) begin
         int w = 0;
         stp = 1'b0;
         if (r % 2 == 0) begin
            while (!(run[0] && !stopped[0] && n[0] == 26) && w < 300) begin
               @(negedge sysclk);
               w++;
            end
            total++;
            if (w >= 300 || x22[0] !== 1'b1) begin
               bad++;
               $display("FAIL x2s2_reach w=%0d x22=%b", w, x22[0]);
            end
         end else repeat ($urandom_range(1, 100)) @(negedge sysclk);
         #2 poc_n = 1'b0;
         #1;
         for (int i = 0; i < 2; i++) begin
            total++;
            if (dutv(i) !== expv(i)) begin
               bad++;
               $display("FAIL async_reset u%0d r=%0d got=%h want=%h", i, r, dutv(i), expv(i));
            end
         end
         @(negedge sysclk);
         poc_n = 1'b1;
         for (int k = 0; k < 200; k++) begin
            stp = 1'($urandom);
            @(negedge sysclk);
            for (int i = 0; i < 2; i++) begin
               total++;
               if (dutv(i) !== expv(i)) begin
                  bad++;
                  $display("FAIL restart u%0d r=%0d k=%0d got=%h want=%h", i, r, k, dutv(i), expv(i));
               end
            end
         end
      end
   endtask

   initial begin
      poc_n = 1'b1;
      stp = 1'b0;
      #2 poc_n = 1'b0;
      test_reset();
      test_free_run();
      test_stop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/timing_seq.md
TIMING_SEQ -- requirements
Module: timing_seq

Interface
REQ-001 Parameter SLOT_TICKS, default 1, number of sysclk cycles per phase slot (legal 1..15).
REQ-002 Parameter POC_CYCLES, default 2, number of full instruction cycles poc stays high after reset release (legal 1..7).
REQ-003 sysclk  input  1  sole clock, all state updates on rising edge.
REQ-004 poc_n  input  1  reset, asynchronous assert, active-low.
REQ-005 stp  input  1  stop request, active-high, level.
REQ-006 clk1, clk2  output  1 each  non-overlapping phase clocks.
REQ-007 sync_n  output  1  low during A1 state, marks instruction-cycle start.
REQ-008 a12, m12, x12  output  1 each  high during clk2 slot of A1, M1, X1.
REQ-009 a22, a32, m22, x22, x32  output  1 each  high during clk2 slot of A2, A3, M2, X2, X3.
REQ-010 x21_clk2, x31_clk2  output  1 each  active-low qualifiers, low during clk2 slot of X2 / X3.
REQ-011 poc  output  1  active-high datapath clear.
REQ-012 stp_ack  output  1  high while sequencer is stopped.
REQ-013 state  output  3  current machine state, A1=0..X3=7.

Function
REQ-014 Machine states SHALL run A1,A2,A3,M1,M2,X1,X2,X3 then wrap to A1; 8 states per instruction cycle.
REQ-015 Each state SHALL consist of four slots in order: S0 clk1 high, S1 gap, S2 clk2 high, S3 gap; each slot lasts SLOT_TICKS sysclk cycles.
REQ-016 clk1 and clk2 SHALL never be high in the same sysclk cycle; each is registered (no glitches).
REQ-017 State SHALL advance on the last tick of S3; slot counter and tick counter SHALL wrap to 0 at that boundary.
REQ-018 Exactly one of a12..x32 SHALL be high per S2 slot, matching state; all low in S0, S1, S3.
REQ-019 sync_n SHALL be low for all four slots of A1, high otherwise.
REQ-020 poc SHALL be high from reset until end of X3 of the POC_CYCLES-th full cycle after poc_n release, then low until next reset.
REQ-021 stp SHALL be sampled on the last tick of X3; if high, sequencer SHALL enter STOPPED at A1 S0 instead of running.
REQ-022 In STOPPED: clk1/clk2 toggle normally, state holds at A1, sync_n high, all strobes low, stp_ack high.
REQ-023 STOPPED SHALL exit when stp sampled low at the last tick of a stopped S3; next cycle is a normal A1 with sync_n low; stp_ack drops in the same sysclk.
REQ-024 stp changes outside the X3 / stopped-S3 sampling point SHALL have no effect.
REQ-025 While poc high, stp SHALL be ignored.

Reset
REQ-026 poc_n low SHALL immediately force: state=A1, slot=S0, tick=0, clk1=0, clk2=0, sync_n=1, all strobes 0, x21_clk2=x31_clk2=1, poc=1, stp_ack=0, poc cycle counter=0.
REQ-027 First sysclk edge after poc_n release SHALL begin A1 S0 (clk1=1, sync_n=0).
REQ-028 Reset asserted mid-cycle or mid-stop SHALL abort and restart per REQ-026/027; no partial state retained.

Configuration
REQ-029 Macro TIMING_SEQ_STOP_EN: defined -> stp/stp_ack behaviour per REQ-021..025; undefined -> stp ignored, stp_ack tied 0, sequencer free-runs.

Verification
REQ-030 SLOT_TICKS=1, release poc_n -> clk1 high at ticks 0,4,8..; clk2 at 2,6,10..; sync_n low ticks 0-3, repeats every 32 ticks.
REQ-031 SLOT_TICKS=3 -> each strobe 3 sysclk wide; instruction cycle 96 sysclk; m12 high ticks 42-44 of cycle.
REQ-032 POC_CYCLES=2 -> poc low exactly at tick 64 after release (SLOT_TICKS=1).
REQ-033 STOP_EN, stp=1 across X3 end -> stp_ack=1, sync_n stays 1 for 3 cycles; stp=0 -> next A1 sync_n=0, stp_ack=0 same edge.
REQ-034 stp pulse high only during M2 -> no stop, sequence unchanged.
REQ-035 poc_n pulsed low during X2 S2 -> x22 drops asynchronously, poc=1, restart at A1 S0.
